fp_mant_align: RTL and testbench

- Pipelined operand-alignment stage sitting directly upstream of the 23-bit mantissa adder in the floating-point add path.
- Compares the two exponents and selects the larger-exponent operand. Right-shifts the smaller operand's significand by the exponent difference.
- Presents two aligned MANT_W-bit significands plus a common exponent, ready for the adder's a/b inputs.
- Two-stage valid/ready pipeline; throughput one operand pair per cycle.

---
 rtl/fp_mant_align.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_mant_align.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_align.sv
// ---------------------------------------------------------------------------
// fp_mant_align
//
// Operand-alignment stage in front of the mantissa adder of the floating-point
// add path. The two exponents are compared, and the operand with the larger
// exponent is selected as the "big" operand. The other significand is
// right-shifted by the exponent difference so that both significands line up
// for the adder's a/b inputs.
//
// The block is a two-stage valid/ready pipeline that accepts one pair per cycle:
//   stage 1 : exponent compare, operand swap, absolute exponent difference
//   stage 2 : right shift of the small significand (plus sticky), output regs
//
// Configuration macro:
//   FP_ALIGN_STICKY_EN - when defined, sticky is the OR of all bits shifted
//                        out of man_small. This value is registered with
//                        stage 2. When the macro is undefined, sticky is tied
//                        to 0 and no sticky logic is built.
//
// Parameters:
//   MANT_W - significand width presented to the adder
//   EXP_W  - exponent width
//   SHW    - shift-amount width, 2**SHW >= MANT_W
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (clears all state)
//   in_valid  in   operand pair valid
//   in_ready  out  stage accepts operands this cycle
//   exp_a     in   exponent of operand A
//   man_a     in   significand of operand A
//   exp_b     in   exponent of operand B
//   man_b     in   significand of operand B
//   out_valid out  aligned result valid
//   out_ready in   downstream accepts result
//   man_big   out  unshifted significand of the larger-exponent operand
//   man_small out  right-shifted significand of the smaller operand
//   exp_out   out  larger exponent
//   swapped   out  1 when B was the larger-exponent operand
//   sticky    out  OR of all bits shifted out of man_small
// ---------------------------------------------------------------------------
module fp_mant_align #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8,
    parameter int SHW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [MANT_W-1:0] man_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MANT_W-1:0] man_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] man_big,
    output logic [MANT_W-1:0] man_small,
    output logic [EXP_W-1:0]  exp_out,
    output logic              swapped,
    output logic              sticky
);

    // -----------------------------------------------------------------------
    // Pipeline control
    // -----------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic adv1;
    logic adv2;

    // Stage 2 may load when it is empty or its content leaves this cycle.
    // Stage 1 may load when it is empty or it can move into stage 2. This
    // gives full throughput with no bubble when a full pipe drains and fills
    // in the same cycle.
    assign adv2     = ~s2_valid_reg | out_ready;
    assign adv1     = ~s1_valid_reg | adv2;
    assign in_ready = adv1;

    // -----------------------------------------------------------------------
    // Stage 1: exponent compare and operand swap
    // -----------------------------------------------------------------------
    logic              swap_next;
    logic [MANT_W-1:0] big_next;
    logic [MANT_W-1:0] small_next;
    logic [EXP_W-1:0]  exp_next;
    logic [EXP_W-1:0]  diff_next;

    logic              s1_swap_reg;
    logic [MANT_W-1:0] s1_big_reg;
    logic [MANT_W-1:0] s1_small_reg;
    logic [EXP_W-1:0]  s1_exp_reg;
    logic [EXP_W-1:0]  s1_diff_reg;

    always_comb begin
        // Equal exponents keep A as the big operand.
        swap_next = (exp_b > exp_a);
        if (swap_next) begin
            big_next   = man_b;
            small_next = man_a;
            exp_next   = exp_b;
            diff_next  = exp_b - exp_a;
        end else begin
            big_next   = man_a;
            small_next = man_b;
            exp_next   = exp_a;
            diff_next  = exp_a - exp_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_swap_reg  <= 1'b0;
            s1_big_reg   <= '0;
            s1_small_reg <= '0;
            s1_exp_reg   <= '0;
            s1_diff_reg  <= '0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            // Data only loads with a real pair, so the registers hold the
            // last pair while the pipe is idle.
            if (in_valid) begin
                s1_swap_reg  <= swap_next;
                s1_big_reg   <= big_next;
                s1_small_reg <= small_next;
                s1_exp_reg   <= exp_next;
                s1_diff_reg  <= diff_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: alignment shift
    // -----------------------------------------------------------------------
    // The full-width difference is compared against MANT_W first. Large gaps
    // (for example 255) therefore flush the operand instead of wrapping in
    // the SHW-bit shifter.
    logic diff_ovf;
    assign diff_ovf = (32'(s1_diff_reg) >= 32'(MANT_W));

    // Log-depth barrel shifter. Level gi shifts by 2**gi when bit gi of the
    // difference is set. Only the low SHW bits are needed once diff_ovf is
    // excluded.
    logic [SHW:0][MANT_W-1:0] shift_stage;
    assign shift_stage[0] = s1_small_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_shift
            assign shift_stage[gi+1] = s1_diff_reg[gi] ? (shift_stage[gi] >> (2**gi))
                                                       : shift_stage[gi];
        end
    endgenerate

    logic [MANT_W-1:0] man_small_next;
    assign man_small_next = diff_ovf ? '0 : shift_stage[SHW];

    logic              s2_swap_reg;
    logic [MANT_W-1:0] s2_big_reg;
    logic [MANT_W-1:0] s2_small_reg;
    logic [EXP_W-1:0]  s2_exp_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_swap_reg  <= 1'b0;
            s2_big_reg   <= '0;
            s2_small_reg <= '0;
            s2_exp_reg   <= '0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_swap_reg  <= s1_swap_reg;
                s2_big_reg   <= s1_big_reg;
                s2_small_reg <= man_small_next;
                s2_exp_reg   <= s1_exp_reg;
            end
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    // below_mask marks the bit positions that fall off the bottom of the
    // significand: bit gi is lost when gi < diff. With diff >= MANT_W every
    // bit is set, so this one expression also covers the flush case, and
    // diff = 0 gives an empty mask.
    logic [MANT_W-1:0] below_mask;
    logic              sticky_next;
    logic              s2_sticky_reg;

    generate
        for (gi = 0; gi < MANT_W; gi++) begin : g_sticky_mask
            assign below_mask[gi] = (32'(s1_diff_reg) > 32'(gi));
        end
    endgenerate

    assign sticky_next = |(s1_small_reg & below_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_sticky_reg <= 1'b0;
        end else if (adv2 && s1_valid_reg) begin
            s2_sticky_reg <= sticky_next;
        end
    end

    assign sticky = s2_sticky_reg;
`else
    assign sticky = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign out_valid = s2_valid_reg;
    assign man_big   = s2_big_reg;
    assign man_small = s2_small_reg;
    assign exp_out   = s2_exp_reg;
    assign swapped   = s2_swap_reg;

endmodule

// File: tb/tb_fp_mant_align.sv
// ---------------------------------------------------------------------------
// tb_fp_mant_align
//
// Self-checking bench for fp_mant_align. A behavioural reference computes each
// aligned result with plain arithmetic: division and remainder by 2**diff.
// A queue holds the pairs that are in flight. Each queued entry records the
// cycle in which it was accepted, so the bench can predict the two-cycle
// latency. in_ready is predicted from the number of pairs in flight.
// ---------------------------------------------------------------------------
module tb_fp_mant_align;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int SHW    = 5;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp_a;
    logic [MANT_W-1:0] man_a;
    logic [EXP_W-1:0]  exp_b;
    logic [MANT_W-1:0] man_b;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] man_big;
    logic [MANT_W-1:0] man_small;
    logic [EXP_W-1:0]  exp_out;
    logic              swapped;
    logic              sticky;

    always #5 clk = ~clk;

    fp_mant_align #(
        .MANT_W(MANT_W),
        .EXP_W (EXP_W),
        .SHW   (SHW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .exp_a    (exp_a),
        .man_a    (man_a),
        .exp_b    (exp_b),
        .man_b    (man_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .man_big  (man_big),
        .man_small(man_small),
        .exp_out  (exp_out),
        .swapped  (swapped),
        .sticky   (sticky)
    );

    typedef struct {
        logic [MANT_W-1:0] mb;
        logic [MANT_W-1:0] ms;
        logic [EXP_W-1:0]  eo;
        logic              sw;
        logic              st;
        int                acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_out = 0;
    logic last_acc = 1'b0;
    logic saw_stall = 1'b0;

    // Reference: align the smaller operand arithmetically.
    function automatic exp_t ref_align(input logic [EXP_W-1:0] ea, input logic [MANT_W-1:0] ma,
                                       input logic [EXP_W-1:0] eb, input logic [MANT_W-1:0] mb);
        exp_t              r;
        int                d;
        logic [MANT_W-1:0] sm;
        logic              rem_nz;
        longint            scale;
        r.sw = (eb > ea);
        r.eo = r.sw ? eb : ea;
        r.mb = r.sw ? mb : ma;
        sm   = r.sw ? ma : mb;
        d    = r.sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        if (d >= MANT_W) begin
            r.ms   = '0;
            rem_nz = (sm != 0);
        end else begin
            scale  = longint'(1) << d;
            r.ms   = MANT_W'(longint'(sm) / scale);
            rem_nz = ((longint'(sm) % scale) != 0);
        end
        r.st      = STICKY_ON & rem_nz;
        r.acc_cyc = 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic v, input logic [EXP_W-1:0] ea, input logic [MANT_W-1:0] ma,
                          input logic [EXP_W-1:0] eb, input logic [MANT_W-1:0] mb);
        in_valid = v;
        exp_a    = ea;
        man_a    = ma;
        exp_b    = eb;
        man_b    = mb;
    endtask

    // One clock cycle: check the outputs against the model before the edge,
    // then apply the handshakes to the model at the edge.
    task automatic tick();
        logic acc;
        logic cons;
        logic exp_ov;
        exp_t e;
        #1;
        if (rst_n) begin
            check("in_ready", in_ready, (sb.size() < 2) || out_ready);
            exp_ov = (sb.size() > 0) && (cyc > sb[0].acc_cyc);
            check("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                check("man_big", man_big, sb[0].mb);
                check("man_small", man_small, sb[0].ms);
                check("exp_out", exp_out, sb[0].eo);
                check("swapped", swapped, sb[0].sw);
                check("sticky", sticky, sb[0].st);
            end
            if (!in_ready) saw_stall = 1'b1;
        end
        acc  = rst_n && in_valid && in_ready;
        cons = rst_n && out_valid && out_ready;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (cons && sb.size() > 0) begin
                void'(sb.pop_front());
                n_out++;
            end
            if (acc) begin
                e = ref_align(exp_a, man_a, exp_b, man_b);
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
        end
        #1;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_man_big", man_big, '0);
            check("rst_man_small", man_small, '0);
            check("rst_exp_out", exp_out, '0);
            check("rst_swapped", swapped, 1'b0);
            check("rst_sticky", sticky, 1'b0);
        end
    endtask

    // Send one pair into an idle pipe. On return the result is on the outputs.
    task automatic one_pair(input logic [EXP_W-1:0] ea, input logic [MANT_W-1:0] ma,
                            input logic [EXP_W-1:0] eb, input logic [MANT_W-1:0] mb);
        set_in(1'b1, ea, ma, eb, mb);
        tick();
        check("dir_accept", last_acc, 1'b1);
        set_in(1'b0, ea, ma, eb, mb);
        tick();
        check("dir_latency_valid", out_valid, 1'b1);
    endtask

    task automatic drain();
        int k;
        set_in(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            tick();
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EXP_W-1:0]  bp_ea[5];
        logic [MANT_W-1:0] bp_ma[5];
        logic [EXP_W-1:0]  bp_eb[5];
        logic [MANT_W-1:0] bp_mb[5];
        int                idx;
        int                k;
        int                out_base;
        logic [EXP_W-1:0]  ea;
        logic [EXP_W-1:0]  eb;

        // Reset held for three cycles while in_valid is high.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 8'd130, 23'h400000, 8'd128, 23'h600003);
        repeat (3) tick();

        // First pair after release: basic alignment with diff = 2.
        rst_n = 1'b1;
        one_pair(8'd130, 23'h400000, 8'd128, 23'h600003);
        check("basic_man_big", man_big, 23'h400000);
        check("basic_man_small", man_small, 23'h180000);
        check("basic_exp_out", exp_out, 8'd130);
        check("basic_swapped", swapped, 1'b0);
        check("basic_sticky", sticky, STICKY_ON);
        tick();

        // B has the larger exponent.
        one_pair(8'd10, 23'h000004, 8'd12, 23'h123456);
        check("swap_swapped", swapped, 1'b1);
        check("swap_exp_out", exp_out, 8'd12);
        check("swap_man_big", man_big, 23'h123456);
        check("swap_man_small", man_small, 23'h000001);
        check("swap_sticky", sticky, 1'b0);
        tick();

        // Equal exponents.
        one_pair(8'd50, 23'h0ABCDE, 8'd50, 23'h13579B);
        check("eq_swapped", swapped, 1'b0);
        check("eq_man_big", man_big, 23'h0ABCDE);
        check("eq_man_small", man_small, 23'h13579B);
        check("eq_sticky", sticky, 1'b0);
        tick();

        // Large difference (198) flushes the operand.
        one_pair(8'd200, 23'h2AAAAA, 8'd2, 23'h000001);
        check("sat198_man_small", man_small, 23'h0);
        check("sat198_sticky", sticky, STICKY_ON);
        tick();

        // Difference exactly MANT_W.
        one_pair(8'd30, 23'h000001, 8'd7, 23'h7FFFFF);
        check("d23_man_small", man_small, 23'h0);
        check("d23_sticky", sticky, STICKY_ON);
        tick();

        // Difference MANT_W-1.
        one_pair(8'd29, 23'h000001, 8'd7, 23'h7FFFFF);
        check("d22_man_small", man_small, 23'h000001);
        check("d22_sticky", sticky, STICKY_ON);
        tick();

        // Backpressure: five pairs, out_ready low for cycles 3-6.
        for (int i = 0; i < 5; i++) begin
            bp_ea[i] = EXP_W'($urandom_range(0, 255));
            bp_eb[i] = EXP_W'($urandom_range(0, 255));
            bp_ma[i] = MANT_W'($urandom);
            bp_mb[i] = MANT_W'($urandom);
        end
        saw_stall = 1'b0;
        out_base  = n_out;
        idx       = 0;
        k         = 0;
        while (idx < 5 && k < 40) begin
            out_ready = !(k >= 2 && k <= 5);
            set_in(1'b1, bp_ea[idx], bp_ma[idx], bp_eb[idx], bp_mb[idx]);
            tick();
            if (last_acc) idx++;
            k++;
        end
        check("bp_all_accepted", idx, 5);
        drain();
        check("bp_count", n_out - out_base, 5);
        check("bp_stall_seen", saw_stall, 1'b1);

        // Randomized traffic. Exponents are mostly close together so that
        // the shift and sticky paths are exercised, with some far apart.
        for (int i = 0; i < 400; i++) begin
            ea = EXP_W'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0)
                eb = ea + EXP_W'($urandom_range(0, 60)) - EXP_W'(30);
            else
                eb = EXP_W'($urandom_range(0, 255));
            set_in($urandom_range(0, 3) != 0, ea, MANT_W'($urandom), eb, MANT_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset while two pairs are in flight: both are discarded.
        out_ready = 1'b0;
        set_in(1'b1, 8'd100, 23'h7FFFFF, 8'd90, 23'h555555);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, '0, '0, '0, '0);
        tick();
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
